// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared definitions for the data-memory write-port arbiter:
//                controller state encoding and default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int DEF_WIDTH = 32;   // data word width
    localparam int DEF_DEPTH = 256;  // number of memory words
    localparam int DEF_ADDR  = 32;   // word-address width

    // Controller phases. RUN is terminal until the next reset.
    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        CLEAR    = 2'd1,
        RUN      = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_clear_seq
//  Description : Zero-fill index sequencer. While start is held, idx walks
//                0..DEPTH-1, one word per cycle, and done flags the final word.
//  Ports       : clk    - clock
//                rst    - asynchronous active-low reset
//                start  - sequencer enabled (level) for this cycle
//                idx    - word index to clear this cycle
//                active - a clear write is issued this cycle
//                done   - this cycle clears the last word
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_clear_seq
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [IDXW-1:0] idx,
    output logic            active,
    output logic            done
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

    assign active = start;
    assign done   = start && (idx == LAST_IDX);

    // Wrap back to 0 after the last word so a later restart begins clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (start) begin
            idx <= done ? '0 : idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Owns the single write port of the data memory (comb read,
//                sync write) and shares it between the CPU MEM stage and an
//                external loader/debug master. Zero-fills memory after reset,
//                gives the CPU priority and bounds ext starvation.
//  Ports       : clk, rst (async active-low)
//                cpu_req/we/addr/wdata -> cpu_rdata, cpu_stall
//                ext_req/we/addr/wdata -> ext_gnt, ext_rdata, ext_rvalid
//                mem_we/addr/wdata, mem_rdata : memory side
//                init_done : zero-fill complete
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int ADDR           = DEF_ADDR,
    parameter int STARVE_LIMIT   = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [ADDR-1:0]  cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    input  logic             ext_req,
    input  logic             ext_we,
    input  logic [ADDR-1:0]  ext_addr,
    input  logic [WIDTH-1:0] ext_wdata,
    output logic             ext_gnt,
    output logic [WIDTH-1:0] ext_rdata,
    output logic             ext_rvalid,
    output logic             mem_we,
    output logic [ADDR-1:0]  mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             init_done
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SCW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SCW-1:0]  STARVE_MAX = SCW'(STARVE_LIMIT);
    localparam logic [ADDR-1:0] DEPTH_A    = ADDR'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [SCW-1:0]    starve_cnt;
    logic [SCW-1:0]    starve_nxt;
    logic [IDXW-1:0]   clr_idx;
    logic              clr_start;
    logic              clr_active;
    logic              clr_done;
    logic              cpu_in_range;
    logic              ext_in_range;
    logic              ext_rd_gnt;

    assign cpu_in_range = (cpu_addr < DEPTH_A);
    assign ext_in_range = (ext_addr < DEPTH_A);
    assign clr_start    = (state == CLEAR);
    assign ext_rd_gnt   = ext_gnt & ~ext_we;

    // Pass-through load data; out-of-range addresses read as zero.
    assign cpu_rdata = cpu_in_range ? mem_rdata : '0;

    dmem_clear_seq #(
        .DEPTH (DEPTH),
        .IDXW  (IDXW)
    ) u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (clr_start),
        .idx    (clr_idx),
        .active (clr_active),
        .done   (clr_done)
    );

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            RST_WAIT: state_nxt = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            CLEAR:    if (clr_done) state_nxt = RUN;
            RUN:      state_nxt = RUN;
            default:  state_nxt = RST_WAIT;
        endcase
    end

    // Grant, memory mux and starvation counter update. Outside RUN the CPU
    // is simply held off; in RUN an ext request wins when the CPU is idle or
    // once it has been denied STARVE_LIMIT consecutive cycles.
    always_comb begin
        ext_gnt    = 1'b0;
        cpu_stall  = cpu_req;
        mem_we     = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        starve_nxt = '0;
        case (state)
            CLEAR: begin
                mem_we    = clr_active;
                mem_addr  = ADDR'(clr_idx);
                mem_wdata = '0;
            end
            RUN: begin
                ext_gnt   = ext_req & (~cpu_req | (starve_cnt == STARVE_MAX));
                cpu_stall = cpu_req & ext_gnt;
                if (ext_gnt) begin
                    mem_addr  = ext_addr;
                    mem_wdata = ext_wdata;
                    mem_we    = ext_we & ext_in_range;
                end else begin
                    mem_we    = cpu_req & cpu_we & cpu_in_range;
                end
                if (ext_req & ~ext_gnt) begin
                    starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt
                                                            : starve_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RST_WAIT;
            starve_cnt <= '0;
            ext_rdata  <= '0;
            ext_rvalid <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            init_done  <= (state_nxt == RUN);
            ext_rvalid <= ext_rd_gnt;
            if (ext_rd_gnt) begin
                ext_rdata <= ext_in_range ? mem_rdata : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with an attached
//                data memory and a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int ADDR  = 32;
    localparam int LIMIT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR-1:0]  cpu_addr = '0;
    logic [WIDTH-1:0] cpu_wdata = '0;
    logic             ext_req = 1'b0, ext_we = 1'b0;
    logic [ADDR-1:0]  ext_addr = '0;
    logic [WIDTH-1:0] ext_wdata = '0;
    wire  [WIDTH-1:0] cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
    wire  [ADDR-1:0]  mem_addr;
    wire              cpu_stall, ext_gnt, ext_rvalid, mem_we, init_done;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR),
        .STARVE_LIMIT(LIMIT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
        .ext_rvalid(ext_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .init_done(init_done)
    );

    // Attached memory: 8-bit index only, so out-of-range addresses alias.
    function automatic logic [WIDTH-1:0] garbage(input int i);
        return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    logic [WIDTH-1:0] ram [DEPTH];
    logic             seeded = 1'b0;
    assign mem_rdata = ram[mem_addr[7:0]];
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= garbage(i);
            seeded <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    int               checks = 0;
    int               errors = 0;
    int               n = 0;        // cycles since reset release
    int               denied = 0;   // consecutive denied ext cycles in RUN
    logic [WIDTH-1:0] mmem [DEPTH];
    logic             m_rvalid = 1'b0;
    logic [WIDTH-1:0] m_rdata = '0;
    logic             m_gnt_last = 1'b0;

    logic             s_gnt, s_stall, s_we, s_rvalid, s_init;
    logic [ADDR-1:0]  s_addr;
    logic [WIDTH-1:0] s_cpu_rdata, s_ext_rdata;

    initial for (int i = 0; i < DEPTH; i++) mmem[i] = garbage(i);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic             run, clr, e_gnt, e_we, inr;
        logic [ADDR-1:0]  a;
        logic [WIDTH-1:0] d;
        s_gnt = ext_gnt; s_stall = cpu_stall; s_we = mem_we; s_addr = mem_addr;
        s_rvalid = ext_rvalid; s_init = init_done;
        s_cpu_rdata = cpu_rdata; s_ext_rdata = ext_rdata;
        if (!rst) begin
            chk("rst_mem_we", mem_we, 0);
            chk("rst_ext_gnt", ext_gnt, 0);
            chk("rst_cpu_stall", cpu_stall, cpu_req);
            chk("rst_init_done", init_done, 0);
            chk("rst_ext_rvalid", ext_rvalid, 0);
            chk("rst_ext_rdata", ext_rdata, 0);
            n = 0; denied = 0; m_rvalid = 0; m_rdata = '0; m_gnt_last = 0;
            return;
        end
        clr = (n >= 1) && (n <= DEPTH);
        run = (n > DEPTH);
        chk("init_done", init_done, run);
        chk("ext_rvalid", ext_rvalid, m_rvalid);
        chk("ext_rdata", ext_rdata, m_rdata);
        e_gnt = 1'b0; e_we = 1'b0; a = cpu_addr; d = cpu_wdata;
        if (!run) begin
            chk("pre_ext_gnt", ext_gnt, 0);
            chk("pre_cpu_stall", cpu_stall, cpu_req);
            chk("pre_mem_we", mem_we, clr);
            if (clr) begin
                chk("clr_addr", mem_addr, n - 1);
                chk("clr_wdata", mem_wdata, 0);
                mmem[n-1] = '0;
            end
        end else begin
            e_gnt = ext_req && (!cpu_req || denied >= LIMIT);
            if (e_gnt) begin
                a = ext_addr; d = ext_wdata; e_we = ext_we;
            end else begin
                e_we = cpu_req && cpu_we;
            end
            inr  = (a < DEPTH);
            e_we = e_we && inr;
            chk("ext_gnt", ext_gnt, e_gnt);
            chk("cpu_stall", cpu_stall, cpu_req && e_gnt);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, a);
            chk("mem_wdata", mem_wdata, d);
            if (!e_gnt)
                chk("cpu_rdata", cpu_rdata, (cpu_addr < DEPTH) ? mmem[cpu_addr[7:0]] : '0);
            // state update as of the coming edge
            m_rvalid = e_gnt && !ext_we;
            if (m_rvalid) m_rdata = (ext_addr < DEPTH) ? mmem[ext_addr[7:0]] : '0;
            if (e_we) mmem[a[7:0]] = d;
            denied = (ext_req && !e_gnt) ? denied + 1 : 0;
        end
        m_gnt_last = e_gnt;
        if (n < 100000) n++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [ADDR-1:0] a, input logic [WIDTH-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic ext_drive(input logic req, input logic we, input logic [ADDR-1:0] a, input logic [WIDTH-1:0] d);
        ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
    endtask

    int       we_cnt, stall_cnt, first_done, guard;
    logic [9:0] gpat, spat;

    initial begin
        // ---- reset and zero-fill ----
        repeat (3) tick();
        cpu_drive(1, 0, 0, 0);
        rst = 1'b1;
        we_cnt = 0; stall_cnt = 0; first_done = 0;
        for (int i = 1; i <= 260; i++) begin
            tick();
            if (s_we) we_cnt++;
            if (s_stall && i < 258) stall_cnt++;
            if (s_init && first_done == 0) first_done = i;
        end
        chk("clear_cycles", we_cnt, 256);
        chk("init_done_cycle", first_done, 258);
        chk("clear_stall_cycles", stall_cnt, 257);

        // ---- store / load ----
        cpu_drive(1, 1, 5, 32'hDEADBEEF); tick();
        chk("st5_we", s_we, 1);
        cpu_drive(1, 0, 5, 0); tick();
        chk("ld5_data", s_cpu_rdata, 32'hDEADBEEF);
        chk("ld5_stall", s_stall, 0);

        // ---- starvation window ----
        cpu_drive(1, 0, 1, 0);
        ext_drive(1, 1, 9, 32'h0000_0099);
        for (int i = 0; i < 10; i++) begin
            tick();
            gpat[i] = s_gnt; spat[i] = s_stall;
        end
        chk("starve_gnt_pattern", gpat, 10'b10_0001_0000);
        chk("starve_stall_pattern", spat, 10'b10_0001_0000);
        ext_drive(0, 0, 0, 0);

        // ---- ext read ----
        cpu_drive(1, 1, 7, 32'h1234); tick();
        cpu_drive(0, 0, 0, 0);
        ext_drive(1, 0, 7, 0); tick();
        chk("extrd_gnt", s_gnt, 1);
        ext_drive(0, 0, 0, 0); tick();
        chk("extrd_rvalid", s_rvalid, 1);
        chk("extrd_rdata", s_ext_rdata, 32'h1234);
        tick();
        chk("extrd_rvalid_end", s_rvalid, 0);

        // ---- out-of-range ----
        cpu_drive(1, 1, 44, 32'h0000_CAFE); tick();
        cpu_drive(1, 1, 300, 32'h5555_AAAA); tick();
        chk("oor_st_we", s_we, 0);
        cpu_drive(1, 0, 300, 0); tick();
        chk("oor_ld_data", s_cpu_rdata, 0);
        cpu_drive(1, 0, 44, 0); tick();
        chk("alias_untouched", s_cpu_rdata, 32'h0000_CAFE);

        // ---- random traffic ----
        for (int i = 0; i < 3000; i++) begin
            cpu_drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                      $urandom_range(0, 299), $urandom);
            if (!(ext_req && !m_gnt_last))
                ext_drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                          $urandom_range(0, 299), $urandom);
            tick();
        end
        cpu_drive(0, 0, 0, 0);
        ext_drive(0, 0, 0, 0);

        // ---- reset in the middle of the zero-fill ----
        rst = 1'b0; tick(); tick();
        rst = 1'b1;
        guard = 0;
        while (n != 101 && guard < 400) begin
            cpu_drive(1, 0, $urandom_range(0, 255), 0);
            tick();
            guard++;
        end
        chk("reach_idx100", guard < 400, 1);
        chk("mid_clear_addr", mem_addr, 100);
        #2 rst = 1'b0;
        #1 chk("async_rst_we", mem_we, 0);
        chk("async_rst_stall", cpu_stall, cpu_req);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("restart_wait_we", s_we, 0);
        tick();
        chk("restart_we", s_we, 1);
        chk("restart_addr", s_addr, 0);
        for (int i = 0; i < 300; i++) begin
            cpu_drive(($urandom_range(0, 1) == 1), $urandom_range(0, 1),
                      $urandom_range(0, 299), $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
